// File: rtl/er_key_stream_checker_if.sv
// Reconciled-key BRAM write streams from the Alice (a_*) and Bob (b_*) sides.
// The engine side drives the master modport. The checker uses the slave modport.
interface er_key_stream_checker_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 15
);
    logic              a_wr_en;
    logic [ADDR_W-1:0] a_wr_addr;
    logic [DATA_W-1:0] a_wr_data;
    logic              b_wr_en;
    logic [ADDR_W-1:0] b_wr_addr;
    logic [DATA_W-1:0] b_wr_data;

    modport master (
        output a_wr_en, a_wr_addr, a_wr_data,
        output b_wr_en, b_wr_addr, b_wr_data
    );

    modport slave (
        input a_wr_en, a_wr_addr, a_wr_data,
        input b_wr_en, b_wr_addr, b_wr_data
    );
endinterface

// File: rtl/er_key_stream_checker.sv
// Buffers the Alice and Bob key streams, compares them pairwise, accumulates frame parameters and issues a done/all_match verdict.
// Define ER_MISMATCH_BITCOUNT_EN to build the mismatch_bit_count popcount accumulator. When it is undefined, that output is tied to 0.
module er_key_stream_checker #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 15,
    parameter int FIFO_AW = 4,
    parameter int LEAK_W  = 16,
    parameter int ERRC_W  = 16,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    er_key_stream_checker_if.slave wr,
    input  logic                   finish_a,
    input  logic                   finish_b,
    input  logic                   frame_param_valid,
    input  logic [LEAK_W-1:0]      frame_leaked_info,
    input  logic [ERRC_W-1:0]      frame_error_count,
    input  logic                   a_verify_fail,
    input  logic                   b_verify_fail,
    output logic [CNT_W-1:0]       word_count,
    output logic [CNT_W-1:0]       mismatch_word_count,
    output logic [CNT_W-1:0]       mismatch_bit_count,
    output logic [ADDR_W-1:0]      first_mismatch_addr,
    output logic                   first_mismatch_valid,
    output logic [CNT_W-1:0]       leaked_total,
    output logic [CNT_W-1:0]       error_total,
    output logic [CNT_W-1:0]       frame_count,
    output logic [CNT_W-1:0]       verify_fail_count,
    output logic                   overflow,
    output logic                   done,
    output logic                   all_match
);
    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int DEPTH  = 1 << FIFO_AW;

    typedef enum logic [2:0] {ST_RUN, ST_DRAIN, ST_RESIDUE, ST_VERDICT, ST_DONE} state_t;

    state_t                  state_reg;
    logic                    fin_a_reg, fin_b_reg, stage_valid_reg;
    logic [CNT_W-1:0]        word_count_reg, mismatch_word_reg, bitcount_reg;
    logic [CNT_W-1:0]        leaked_reg, error_reg, frame_reg, vfail_reg;
    logic [ADDR_W-1:0]       first_addr_reg;
    logic                    first_valid_reg, overflow_reg, done_reg, all_match_reg;

    logic                    accept_in, pair_pop, stage_mismatch;
    logic [1:0]              wr_en_s, empty_s, full_s, push_s, pop_s, drop_s, res_pop_s;
    logic [1:0][WORD_W-1:0]  wr_word_s, rd_word_s;
    logic [CNT_W-1:0]        res_words;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // New writes are taken only while the run is live. Once residue drain starts, they are ignored.
    assign accept_in = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign pair_pop  = accept_in && !empty_s[0] && !empty_s[1];

    assign wr_en_s      = {wr.b_wr_en, wr.a_wr_en};
    assign wr_word_s[0] = {wr.a_wr_addr, wr.a_wr_data};
    assign wr_word_s[1] = {wr.b_wr_addr, wr.b_wr_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WORD_W-1:0]  mem [DEPTH];
            logic [WORD_W-1:0]  rd_word_reg;
            logic [FIFO_AW:0]   wr_ptr_reg, rd_ptr_reg;

            assign empty_s[gi]   = (wr_ptr_reg == rd_ptr_reg);
            assign full_s[gi]    = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                                   (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
            assign res_pop_s[gi] = (state_reg == ST_RESIDUE) && !empty_s[gi];
            assign pop_s[gi]     = pair_pop || res_pop_s[gi];
            assign push_s[gi]    = accept_in && wr_en_s[gi] && (!full_s[gi] || pop_s[gi]);
            assign drop_s[gi]    = accept_in && wr_en_s[gi] && !push_s[gi];
            assign rd_word_s[gi] = rd_word_reg;

            // The registered RAM read doubles as the compare-stage register.
            always_ff @(posedge clk) begin
                if (push_s[gi]) mem[wr_ptr_reg[FIFO_AW-1:0]] <= wr_word_s[gi];
                if (pop_s[gi])  rd_word_reg <= mem[rd_ptr_reg[FIFO_AW-1:0]];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push_s[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop_s[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign stage_mismatch = (rd_word_s[0] != rd_word_s[1]);
    assign res_words      = CNT_W'(res_pop_s[0]) + CNT_W'(res_pop_s[1]);

`ifdef ER_MISMATCH_BITCOUNT_EN
    logic [DATA_W-1:0] diff_vec;
    logic [CNT_W-1:0]  diff_bits;
    assign diff_vec = rd_word_s[0][DATA_W-1:0] ^ rd_word_s[1][DATA_W-1:0];
    always_comb begin
        diff_bits = '0;
        for (int i = 0; i < DATA_W; i++) diff_bits = diff_bits + CNT_W'(diff_vec[i]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_RUN;
            fin_a_reg         <= 1'b0;
            fin_b_reg         <= 1'b0;
            stage_valid_reg   <= 1'b0;
            word_count_reg    <= '0;
            mismatch_word_reg <= '0;
            bitcount_reg      <= '0;
            leaked_reg        <= '0;
            error_reg         <= '0;
            frame_reg         <= '0;
            vfail_reg         <= '0;
            first_addr_reg    <= '0;
            first_valid_reg   <= 1'b0;
            overflow_reg      <= 1'b0;
            done_reg          <= 1'b0;
            all_match_reg     <= 1'b0;
        end else begin
            stage_valid_reg <= pair_pop;
            if (|drop_s) overflow_reg <= 1'b1;

            if (stage_valid_reg) begin
                word_count_reg <= sat_add(word_count_reg, CNT_W'(1));
                if (stage_mismatch) begin
                    mismatch_word_reg <= sat_add(mismatch_word_reg, CNT_W'(1));
                    if (!first_valid_reg) begin
                        first_addr_reg  <= rd_word_s[0][WORD_W-1:DATA_W];
                        first_valid_reg <= 1'b1;
                    end
                end
`ifdef ER_MISMATCH_BITCOUNT_EN
                bitcount_reg <= sat_add(bitcount_reg, diff_bits);
`endif
            end else if (|res_pop_s) begin
                // Unpaired words left after both finishes count as whole-word mismatches.
                mismatch_word_reg <= sat_add(mismatch_word_reg, res_words);
`ifdef ER_MISMATCH_BITCOUNT_EN
                bitcount_reg <= sat_add(bitcount_reg, res_words * CNT_W'(DATA_W));
`endif
            end

            if (accept_in && frame_param_valid) begin
                frame_reg  <= sat_add(frame_reg, CNT_W'(1));
                leaked_reg <= sat_add(leaked_reg, CNT_W'(frame_leaked_info));
                error_reg  <= sat_add(error_reg, CNT_W'(frame_error_count));
                vfail_reg  <= sat_add(vfail_reg, CNT_W'(a_verify_fail | b_verify_fail));
            end

            case (state_reg)
                ST_RUN: begin
                    if (finish_a) fin_a_reg <= 1'b1;
                    if (finish_b) fin_b_reg <= 1'b1;
                    if ((fin_a_reg || finish_a) && (fin_b_reg || finish_b)) state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pair_pop && !stage_valid_reg)
                        state_reg <= (&empty_s) ? ST_VERDICT : ST_RESIDUE;
                end
                ST_RESIDUE: begin
                    if (&empty_s) state_reg <= ST_VERDICT;
                end
                ST_VERDICT: begin
                    done_reg      <= 1'b1;
                    all_match_reg <= (mismatch_word_reg == '0) && !overflow_reg &&
                                     (vfail_reg == '0) && (frame_reg != '0);
                    state_reg     <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign word_count           = word_count_reg;
    assign mismatch_word_count  = mismatch_word_reg;
`ifdef ER_MISMATCH_BITCOUNT_EN
    assign mismatch_bit_count   = bitcount_reg;
`else
    assign mismatch_bit_count   = '0;
`endif
    assign first_mismatch_addr  = first_addr_reg;
    assign first_mismatch_valid = first_valid_reg;
    assign leaked_total         = leaked_reg;
    assign error_total          = error_reg;
    assign frame_count          = frame_reg;
    assign verify_fail_count    = vfail_reg;
    assign overflow             = overflow_reg;
    assign done                 = done_reg;
    assign all_match            = all_match_reg;
endmodule

// File: tb/tb_er_key_stream_checker.sv
// Directed and randomized scenarios for er_key_stream_checker.
// A queue-based reference model computes the expected verdict from the accepted Alice/Bob words and frame parameters.
module tb_er_key_stream_checker;
    localparam int DATA_W = 64, ADDR_W = 15, FIFO_AW = 4, LEAK_W = 16, ERRC_W = 16, CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    er_key_stream_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

    logic              finish_a, finish_b, frame_param_valid, a_verify_fail, b_verify_fail;
    logic [LEAK_W-1:0] frame_leaked_info;
    logic [ERRC_W-1:0] frame_error_count;
    logic [CNT_W-1:0]  word_count, mismatch_word_count, mismatch_bit_count;
    logic [CNT_W-1:0]  leaked_total, error_total, frame_count, verify_fail_count;
    logic [ADDR_W-1:0] first_mismatch_addr;
    logic              first_mismatch_valid, overflow, done, all_match;

    er_key_stream_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW),
        .LEAK_W(LEAK_W), .ERRC_W(ERRC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr_if),
        .finish_a(finish_a), .finish_b(finish_b),
        .frame_param_valid(frame_param_valid),
        .frame_leaked_info(frame_leaked_info), .frame_error_count(frame_error_count),
        .a_verify_fail(a_verify_fail), .b_verify_fail(b_verify_fail),
        .word_count(word_count), .mismatch_word_count(mismatch_word_count),
        .mismatch_bit_count(mismatch_bit_count),
        .first_mismatch_addr(first_mismatch_addr), .first_mismatch_valid(first_mismatch_valid),
        .leaked_total(leaked_total), .error_total(error_total), .frame_count(frame_count),
        .verify_fail_count(verify_fail_count), .overflow(overflow),
        .done(done), .all_match(all_match)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    int      tests = 0;
    int      fails = 0;
    word_t   qa[$];
    word_t   qb[$];
    longint  exp_leak, exp_err, exp_frames, exp_vfail;
    logic    exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_if.a_wr_en = 1'b0; wr_if.a_wr_addr = '0; wr_if.a_wr_data = '0;
        wr_if.b_wr_en = 1'b0; wr_if.b_wr_addr = '0; wr_if.b_wr_data = '0;
        finish_a = 1'b0; finish_b = 1'b0; frame_param_valid = 1'b0;
        frame_leaked_info = '0; frame_error_count = '0;
        a_verify_fail = 1'b0; b_verify_fail = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        qa.delete(); qb.delete();
        exp_leak = 0; exp_err = 0; exp_frames = 0; exp_vfail = 0; exp_ovf = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drive_a(input word_t w);
        wr_if.a_wr_en = 1'b1; wr_if.a_wr_addr = w.addr; wr_if.a_wr_data = w.data;
        qa.push_back(w);
    endtask

    task automatic drive_b(input word_t w);
        wr_if.b_wr_en = 1'b1; wr_if.b_wr_addr = w.addr; wr_if.b_wr_data = w.data;
        qb.push_back(w);
    endtask

    task automatic write_pair(input word_t wa, input word_t wb);
        drive_a(wa);
        drive_b(wb);
        tick();
        idle();
    endtask

    task automatic send_frame(input int leak, input int err, input logic af, input logic bf);
        frame_param_valid = 1'b1;
        frame_leaked_info = LEAK_W'(leak); frame_error_count = ERRC_W'(err);
        a_verify_fail = af; b_verify_fail = bf;
        exp_frames++; exp_leak += leak; exp_err += err; exp_vfail += (af | bf) ? 1 : 0;
        tick();
        idle();
    endtask

    task automatic do_finish(input int mode, input int gap);
        if (mode == 0) begin
            finish_a = 1'b1; finish_b = 1'b1;
            tick();
            idle();
        end else begin
            if (mode == 1) finish_a = 1'b1; else finish_b = 1'b1;
            tick();
            idle();
            repeat (gap) tick();
            if (mode == 1) finish_b = 1'b1; else finish_a = 1'b1;
            tick();
            idle();
        end
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 400 && done !== 1'b1; c++) tick();
        chk({tag, ".done_reached"}, 64'(done), 64'd1);
    endtask

    // Verdict from the spec rules: index-wise compare of the accepted words, then unpaired words as whole mismatches.
    task automatic check_all(input string tag);
        int     n, resid;
        longint mm, bits;
        logic   fv;
        logic [ADDR_W-1:0] fa;
        logic   am;
        n = (qa.size() < qb.size()) ? qa.size() : qb.size();
        resid = (qa.size() > qb.size()) ? qa.size() - qb.size() : qb.size() - qa.size();
        mm = 0; bits = 0; fv = 1'b0; fa = '0;
        for (int i = 0; i < n; i++) begin
            if (qa[i] != qb[i]) begin
                mm++;
                if (!fv) begin fv = 1'b1; fa = qa[i].addr; end
            end
            bits += $countones(qa[i].data ^ qb[i].data);
        end
        mm += resid;
        bits += longint'(resid) * DATA_W;
`ifndef ER_MISMATCH_BITCOUNT_EN
        bits = 0;
`endif
        am = (mm == 0) && !exp_ovf && (exp_vfail == 0) && (exp_frames != 0);
        chk({tag, ".word_count"}, 64'(word_count), 64'(n));
        chk({tag, ".mismatch_words"}, 64'(mismatch_word_count), 64'(mm));
        chk({tag, ".mismatch_bits"}, 64'(mismatch_bit_count), 64'(bits));
        chk({tag, ".first_valid"}, 64'(first_mismatch_valid), 64'(fv));
        if (fv) chk({tag, ".first_addr"}, 64'(first_mismatch_addr), 64'(fa));
        chk({tag, ".leaked"}, 64'(leaked_total), 64'(exp_leak));
        chk({tag, ".errors"}, 64'(error_total), 64'(exp_err));
        chk({tag, ".frames"}, 64'(frame_count), 64'(exp_frames));
        chk({tag, ".vfail"}, 64'(verify_fail_count), 64'(exp_vfail));
        chk({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".all_match"}, 64'(all_match), 64'(am));
        $display("[TB] %s: words=%0d mism=%0d bits=%0d frames=%0d done=%0b all_match=%0b",
                 tag, word_count, mismatch_word_count, mismatch_bit_count, frame_count, done, all_match);
    endtask

    task automatic scenario_clean(input string tag);
        word_t w;
        send_frame(int'($urandom_range(500, 0)), int'($urandom_range(20, 0)), 1'b0, 1'b0);
        w.addr = '0; w.data = 64'hA5A5_A5A5_A5A5_A5A5;
        write_pair(w, w);
        tick();
        chk({tag, ".latency_1"}, 64'(word_count), 64'd0);
        tick();
        chk({tag, ".latency_2"}, 64'(word_count), 64'd1);
        for (int i = 1; i < 8; i++) begin
            w.addr = ADDR_W'(i);
            write_pair(w, w);
        end
        do_finish(0, 0);
        wait_done(tag);
        check_all(tag);
    endtask

    task automatic run_random(input string tag, input int n);
        word_t wa[$];
        word_t wb[$];
        word_t w;
        int ia, ib, nf;
        for (int i = 0; i < n; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64();
            wa.push_back(w);
            if ($urandom_range(5, 0) == 0) w.data = w.data ^ rnd64();
            if ($urandom_range(9, 0) == 0) w.addr = w.addr ^ ADDR_W'(1 << $urandom_range(ADDR_W - 1, 0));
            wb.push_back(w);
        end
        ia = 0; ib = 0;
        while (ia < n || ib < n) begin
            if (ia < n && ia - ib < 8 && $urandom_range(1, 0) == 1) begin drive_a(wa[ia]); ia++; end
            if (ib < n && ib - ia < 8 && $urandom_range(1, 0) == 1) begin drive_b(wb[ib]); ib++; end
            tick();
            idle();
        end
        nf = int'($urandom_range(3, 1));
        for (int f = 0; f < nf; f++)
            send_frame(int'($urandom_range(60000, 0)), int'($urandom_range(60000, 0)),
                       $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
        do_finish(int'($urandom_range(2, 0)), int'($urandom_range(20, 0)));
        wait_done(tag);
        check_all(tag);
    endtask

    initial begin
        word_t w, wb;
        logic [63:0] mask;

        reset_dut();
        chk("reset.word_count", 64'(word_count), 64'd0);
        chk("reset.mismatch_words", 64'(mismatch_word_count), 64'd0);
        chk("reset.frames", 64'(frame_count), 64'd0);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.all_match", 64'(all_match), 64'd0);

        // Eight identical pairs with a simultaneous finish.
        scenario_clean("clean");
        // Writes, frame strobes and finishes after done must leave everything frozen.
        w.addr = 15'd9; w.data = rnd64(); wb = w; wb.data = ~w.data;
        wr_if.a_wr_en = 1'b1; wr_if.a_wr_addr = w.addr; wr_if.a_wr_data = w.data;
        wr_if.b_wr_en = 1'b1; wr_if.b_wr_addr = wb.addr; wr_if.b_wr_data = wb.data;
        frame_param_valid = 1'b1; frame_leaked_info = 16'd77; b_verify_fail = 1'b1;
        tick();
        idle();
        repeat (5) tick();
        check_all("frozen");

        // Two mismatches: bits 0 and 63 at addr 3, then a random difference at addr 5.
        reset_dut();
        send_frame(10, 1, 1'b0, 1'b0);
        mask = rnd64();
        if (mask == 64'd0) mask = 64'd1;
        for (int i = 0; i < 8; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64(); wb = w;
            if (i == 3) wb.data = w.data ^ {1'b1, 62'd0, 1'b1};
            if (i == 5) wb.data = w.data ^ mask;
            write_pair(w, wb);
        end
        do_finish(1, 3);
        wait_done("mismatch");
        check_all("mismatch");

        // Alice writes 20 words with Bob idle. Only 16 fit, so the rest are dropped.
        reset_dut();
        send_frame(5, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64();
            wr_if.a_wr_en = 1'b1; wr_if.a_wr_addr = w.addr; wr_if.a_wr_data = w.data;
            if (i < 16) qa.push_back(w);
            tick();
        end
        idle();
        exp_ovf = 1'b1;
        do_finish(0, 0);
        wait_done("overflow");
        check_all("overflow");

        // Length mismatch: Alice 5 words, Bob 3 words, finish_b 50 cycles before finish_a.
        reset_dut();
        send_frame(8, 2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64();
            drive_a(w);
            if (i < 3) drive_b(w);
            tick();
            idle();
        end
        do_finish(2, 50);
        wait_done("length");
        check_all("length");

        // Frame parameter accumulation, with a Bob verify fail on frame 2.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64();
            write_pair(w, w);
        end
        send_frame(100, 4, 1'b0, 1'b0);
        send_frame(200, 0, 1'b0, 1'b1);
        send_frame(300, 7, 1'b0, 1'b0);
        do_finish(1, 10);
        wait_done("frames");
        check_all("frames");

        // Reset while draining. Nothing survives, and no verdict appears afterwards.
        reset_dut();
        send_frame(1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w.addr = ADDR_W'(i); w.data = rnd64();
            drive_a(w); drive_b(w);
            if (i == 7) begin finish_a = 1'b1; finish_b = 1'b1; end
            tick();
            idle();
        end
        tick();
        reset_dut();
        chk("midrst.word_count", 64'(word_count), 64'd0);
        chk("midrst.frames", 64'(frame_count), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        repeat (20) tick();
        chk("midrst.idle_done", 64'(done), 64'd0);
        chk("midrst.idle_words", 64'(word_count), 64'd0);
        scenario_clean("rerun");

        for (int r = 0; r < 4; r++) begin
            reset_dut();
            run_random($sformatf("random%0d", r), int'($urandom_range(40, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
